// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad entry into an M:SS BCD register, one-second
// countdown while cooking, and start/stop/clear/door-interlock control of the magnetron.
module microwave_timer_ctrl #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] minutes,
    output logic [3:0] tens_sec,
    output logic [3:0] units_sec,
    output logic       mag_on,
    output logic       done
);

    localparam int unsigned PreW = $clog2(CLK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StSet, StCook, StPause, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      min_q, min_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      units_q, units_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic            mag_q, done_q;

    logic       key_ok;
    logic       time_zero;
    logic       tick;
    logic       dec_to_zero;
    logic [3:0] dec_min, dec_tens, dec_units;

    // A digit is legal only if it is BCD and the digit it pushes into tens stays 0-5.
    assign key_ok      = keypad_valid && (keypad_digit <= 4'd9) && (units_q <= 4'd5);
    assign time_zero   = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);
    assign tick        = (pre_q == PreMax);
    assign dec_to_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd1);

    // One-second decrement with borrow chain units -> tens -> minutes.
    always_comb begin
        dec_min   = min_q;
        dec_tens  = tens_q;
        dec_units = units_q;
        if (units_q != 4'd0) begin
            dec_units = units_q - 4'd1;
        end else begin
            dec_units = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        pre_d   = pre_q;

        if (clear) begin
            state_d = StSet;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                StSet: begin
                    if (stop) begin
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        units_d = 4'd0;
                    end else if (start && door_closed && !time_zero) begin
                        state_d = StCook;
                        pre_d   = '0;
                    end else if (key_ok) begin
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = keypad_digit;
                    end
                end
                StCook: begin
                    if (!door_closed || stop) begin
                        state_d = StPause;
                    end else if (time_zero) begin
                        state_d = StDone;
                    end else if (tick) begin
                        pre_d   = '0;
                        min_d   = dec_min;
                        tens_d  = dec_tens;
                        units_d = dec_units;
                        if (dec_to_zero) begin
                            state_d = StDone;
                        end
                    end else begin
                        pre_d = pre_q + PreW'(1);
                    end
                end
                StPause: begin
                    if (stop) begin
                        state_d = StSet;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        units_d = 4'd0;
                        pre_d   = '0;
                    end else if (start && door_closed) begin
                        state_d = StCook;
                    end
                end
                StDone: begin
                    if (stop) begin
                        state_d = StSet;
                        pre_d   = '0;
                    end else if (key_ok) begin
                        state_d = StSet;
                        pre_d   = '0;
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = keypad_digit;
                    end
                end
                default: begin
                    state_d = StSet;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSet;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            pre_q   <= '0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            pre_q   <= pre_d;
            mag_q   <= (state_d == StCook);
            done_q  <= (state_d == StDone);
        end
    end

    assign minutes   = min_q;
    assign tens_sec  = tens_q;
    assign units_sec = units_q;
    assign mag_on    = mag_q;
    assign done      = done_q;

endmodule
